tt_sweep_ctrl: RTL

Sequencer that drives a 7-input single-output logic function (majority-graph netlist under test) through all 2^N_IN minterms in ascending order, captures the response into a truth table, and compares it with an expected table. It sits between the classification harness (start/expected/results) and the function-under-test (x/fn_out). It shares one function instance across sweeps and tolerates a fixed pipeline latency in the function path.

---
 rtl/tt_sweep_pkg.sv | 25 ++
 rtl/tt_sweep_ctrl_dly.sv | 35 +++
 rtl/tt_sweep_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared constants and types for the truth-table sweep sequencer.
//   N_IN_DEF  : default number of function inputs
//   tt_w()    : truth-table width (2**n) for an n-input function
//   sweep_state_t : sequencer state encoding
//   MAJ_EX_TT : golden table of the reference majority-graph function
package tt_sweep_pkg;

    localparam int N_IN_DEF = 7;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    localparam int TT_W_DEF = tt_w(N_IN_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam logic [127:0] MAJ_EX_TT = 128'hfeeaeae8ece8e8c0fce8e8c8e8a8a880;

endpackage

// File: rtl/tt_sweep_ctrl_dly.sv
// tt_idx_delay: LAT-stage shift register carrying {valid, index} alongside the
// function-under-test pipeline. With LAT=0 it is a wire.
//   clk, rst            : clock, async active-high reset (clears all stages)
//   in_valid, in_idx    : index issued this cycle
//   out_valid, out_idx  : index whose response is on fn_out this cycle
module tt_idx_delay #(
    parameter int LAT = 0,
    parameter int IW  = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [IW-1:0] in_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx
);

    // At least one stage is always declared so LAT=0 still elaborates cleanly;
    // the output mux bypasses it in that case.
    localparam int D = (LAT > 0) ? LAT : 1;

    logic [IW:0] pipe [D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {in_valid, in_idx};
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {out_valid, out_idx} = (LAT == 0) ? {in_valid, in_idx} : pipe[D-1];

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: walks x through every minterm 0..TT_W-1, captures fn_out into
// truth_table and compares the capture against the expected table latched at
// start.
//   clk, rst      : clock, async active-high reset
//   start         : begin a sweep (accepted in IDLE or DONE)
//   expected      : golden table, latched on accepted start
//   busy, done    : sweep in progress / one-cycle results-final pulse
//   x, fn_out     : minterm to function-under-test, its response
//   truth_table   : captured responses
//   match, mismatch_cnt, first_err, err_valid : comparison results
//
// state | meaning
// IDLE  | waiting for start, results held
// SWEEP | issuing x = 0..TT_W-1, one per cycle
// DRAIN | last index issued, waiting LAT cycles for its response
// DONE  | results final, done high for this one cycle
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int LAT  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [tt_w(N_IN)-1:0]  expected,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN-1:0]        x,
    input  logic                   fn_out,
    output logic [tt_w(N_IN)-1:0]  truth_table,
    output logic                   match,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_err,
    output logic                   err_valid
);

    localparam int TT_W = tt_w(N_IN);
    localparam int DW   = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [N_IN-1:0] X_LAST = N_IN'(TT_W - 1);

    sweep_state_t      state;
    logic [TT_W-1:0]   exp_q;
    logic [DW-1:0]     drain_cnt;

    logic              smp_valid;
    logic [N_IN-1:0]   smp_idx;
    logic              start_acc;

    logic [TT_W-1:0]   tt_nxt;
    logic [N_IN:0]     cnt_nxt;
    logic [N_IN-1:0]   first_nxt;
    logic              errv_nxt;

    assign busy      = (state == SWEEP) || (state == DRAIN);
    assign done      = (state == DONE);
    assign start_acc = start && ((state == IDLE) || (state == DONE));

    tt_idx_delay #(
        .LAT (LAT),
        .IW  (N_IN)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state == SWEEP),
        .in_idx    (x),
        .out_valid (smp_valid),
        .out_idx   (smp_idx)
    );

    always_comb begin
        tt_nxt    = truth_table;
        cnt_nxt   = mismatch_cnt;
        first_nxt = first_err;
        errv_nxt  = err_valid;
        if (smp_valid) begin
            tt_nxt[smp_idx] = fn_out;
            if (fn_out != exp_q[smp_idx]) begin
                cnt_nxt = mismatch_cnt + (N_IN+1)'(1);
                if (!err_valid) begin
                    first_nxt = smp_idx;
                    errv_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            x            <= '0;
            exp_q        <= '0;
            drain_cnt    <= '0;
            truth_table  <= '0;
            match        <= 1'b0;
            mismatch_cnt <= '0;
            first_err    <= '0;
            err_valid    <= 1'b0;
        end else begin
            truth_table  <= tt_nxt;
            mismatch_cnt <= cnt_nxt;
            first_err    <= first_nxt;
            err_valid    <= errv_nxt;

            // match uses the next-count so the final sample taken on the
            // edge into DONE is included and match is valid alongside done.
            case (state)
                SWEEP: begin
                    if (x == X_LAST) begin
                        if (LAT == 0) begin
                            state <= DONE;
                            match <= (cnt_nxt == '0);
                        end else begin
                            state <= DRAIN;
                        end
                        drain_cnt <= DW'((LAT > 0) ? LAT - 1 : 0);
                    end else begin
                        x <= x + N_IN'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        match <= (cnt_nxt == '0);
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // No sample can be in flight in IDLE/DONE, so overriding the
            // result registers here never drops a response.
            if (start_acc) begin
                state        <= SWEEP;
                x            <= '0;
                exp_q        <= expected;
                truth_table  <= '0;
                match        <= 1'b0;
                mismatch_cnt <= '0;
                first_err    <= '0;
                err_valid    <= 1'b0;
            end
        end
    end

endmodule
